adc_scan_sequencer: RTL and testbench

Multi-channel scan controller that sits in front of the SAR ADC core and sequences conversions over an analog input mux. It selects channels from a latched enable mask, pulses the ADC start, tracks the ADC sample/ready handshake, and presents each result tagged with its channel. It supports single-shot and continuous scanning, and uses a watchdog to recover from a stalled ADC.

---
 rtl/adc_scan_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: scans an analog mux in front of a SAR ADC.
// Ports: clk_i/rst_i; enable_i, trig_i, continuous_i, ch_mask_i
// (scan control); adc_sample_i, adc_rdy_i, adc_result_i (ADC status);
// adc_start_o, ch_sel_o (ADC/mux drive); busy_o, result_valid_o,
// result_ch_o, result_data_o, scan_done_o, timeout_o (results).
module adc_scan_sequencer #(
  parameter int RESOLUTION = 8,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = $clog2(NUM_CH),
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  trig_i,
  input  logic                  continuous_i,
  input  logic [NUM_CH-1:0]     ch_mask_i,
  input  logic                  adc_sample_i,
  input  logic                  adc_rdy_i,
  input  logic [RESOLUTION-1:0] adc_result_i,
  output logic                  adc_start_o,
  output logic [CH_W-1:0]       ch_sel_o,
  output logic                  busy_o,
  output logic                  result_valid_o,
  output logic [CH_W-1:0]       result_ch_o,
  output logic [RESOLUTION-1:0] result_data_o,
  output logic                  scan_done_o,
  output logic                  timeout_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_SAMPLE,
    WAIT_RDY,
    NEXT
  } state_t;

  state_t state, state_nxt;

  logic [NUM_CH-1:0]     mask_q;
  logic                  cont_q;
  logic [CH_W-1:0]       ch_sel_q;
  logic [CH_W-1:0]       ch_sel_nxt;
  logic [CH_W-1:0]       res_ch_q;
  logic [RESOLUTION-1:0] res_data_q;
  logic [WD_W-1:0]       wd_cnt;
  logic                  wd_hit;
  logic                  timeout_q;
  logic                  load;
  logic                  capture;
  logic                  abort;

  logic                  higher_found;
  logic [CH_W-1:0]       higher_ch;
  logic [CH_W-1:0]       lowest_ch;
  logic [CH_W-1:0]       trig_low_ch;

  // wd_cnt is 0 in the first WAIT_SAMPLE cycle, so the
  // TIMEOUT-th waiting cycle is the one showing TIMEOUT-1.
  assign wd_hit = (wd_cnt == WD_W'(TIMEOUT - 1));

  // Descending scan: the last hit is the lowest index.
  always_comb begin
    higher_found = 1'b0;
    higher_ch    = '0;
    lowest_ch    = '0;
    trig_low_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (CH_W'(i) > ch_sel_q)) begin
        higher_found = 1'b1;
        higher_ch    = CH_W'(i);
      end
      if (mask_q[i]) begin
        lowest_ch = CH_W'(i);
      end
      if (ch_mask_i[i]) begin
        trig_low_ch = CH_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    ch_sel_nxt = ch_sel_q;
    load       = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (trig_i && enable_i && (|ch_mask_i)) begin
          load       = 1'b1;
          ch_sel_nxt = trig_low_ch;
          state_nxt  = START;
        end
      end
      START: begin
        state_nxt = WAIT_SAMPLE;
      end
      WAIT_SAMPLE: begin
        // adc_rdy_i is deliberately not looked at here: it may
        // still be high from the previous conversion.
        if (adc_sample_i) begin
          state_nxt = WAIT_RDY;
        end else if (wd_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_RDY: begin
        if (adc_rdy_i) begin
          capture   = 1'b1;
          state_nxt = NEXT;
        end else if (wd_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      NEXT: begin
        if (!enable_i) begin
          state_nxt = IDLE;
        end else if (higher_found) begin
          ch_sel_nxt = higher_ch;
          state_nxt  = START;
        end else if (cont_q) begin
          ch_sel_nxt = lowest_ch;
          state_nxt  = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q   <= '0;
      cont_q   <= 1'b0;
      ch_sel_q <= '0;
    end else begin
      ch_sel_q <= ch_sel_nxt;
      if (load) begin
        mask_q <= ch_mask_i;
        cont_q <= continuous_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_ch_q   <= '0;
      res_data_q <= '0;
    end else if (capture) begin
      res_ch_q   <= ch_sel_q;
      res_data_q <= adc_result_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= abort;
      if (state == START) begin
        wd_cnt <= '0;
      end else if ((state == WAIT_SAMPLE) || (state == WAIT_RDY)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  // Pass completion depends only on registered mask/channel,
  // so scan_done_o has no combinational path from enable_i.
  assign adc_start_o    = (state == START);
  assign busy_o         = (state != IDLE);
  assign result_valid_o = (state == NEXT);
  assign scan_done_o    = (state == NEXT) && !higher_found;
  assign ch_sel_o       = ch_sel_q;
  assign result_ch_o    = res_ch_q;
  assign result_data_o  = res_data_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed scoreboard bench for the scan
// sequencer with a behavioural SAR ADC model (result = 16*ch+1).
module tb_adc_scan_sequencer;

  localparam int R  = 8;
  localparam int NC = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          trig = 1'b0;
  logic          continuous = 1'b0;
  logic [NC-1:0] ch_mask = '0;
  logic          adc_sample = 1'b0;
  logic          adc_rdy = 1'b0;
  logic [R-1:0]  adc_result = '0;
  logic          adc_start_o;
  logic [CW-1:0] ch_sel_o;
  logic          busy_o;
  logic          result_valid_o;
  logic [CW-1:0] result_ch_o;
  logic [R-1:0]  result_data_o;
  logic          scan_done_o;
  logic          timeout_o;

  adc_scan_sequencer #(
    .RESOLUTION(R),
    .NUM_CH(NC),
    .TIMEOUT(64)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .enable_i(enable),
    .trig_i(trig),
    .continuous_i(continuous),
    .ch_mask_i(ch_mask),
    .adc_sample_i(adc_sample),
    .adc_rdy_i(adc_rdy),
    .adc_result_i(adc_result),
    .adc_start_o(adc_start_o),
    .ch_sel_o(ch_sel_o),
    .busy_o(busy_o),
    .result_valid_o(result_valid_o),
    .result_ch_o(result_ch_o),
    .result_data_o(result_data_o),
    .scan_done_o(scan_done_o),
    .timeout_o(timeout_o)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: sample at t1, rdy cleared after t1 (or already
  // at start unless stale_mode), rdy+result at t(R+2).
  bit          stale_mode = 1'b0;
  bit          never_sample = 1'b0;
  int          conv_t = 0;
  logic [1:0]  conv_ch = '0;

  always @(posedge clk) begin
    if (adc_start_o && !never_sample) begin
      adc_sample <= 1'b1;
      conv_t     <= 1;
      conv_ch    <= ch_sel_o;
      if (!stale_mode) adc_rdy <= 1'b0;
    end else if (conv_t > 0) begin
      adc_sample <= 1'b0;
      if (conv_t == 1) adc_rdy <= 1'b0;
      if (conv_t == R + 1) begin
        adc_rdy    <= 1'b1;
        adc_result <= 8'(16 * int'(conv_ch) + 1);
        conv_t     <= 0;
      end else begin
        conv_t <= conv_t + 1;
      end
    end
  end

  typedef struct {
    bit is_to;
    int ch;
    int data;
    bit done;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  function automatic void push(bit to, int ch, int data,
                               bit done, int c);
    exp_t x;
    x.is_to = to;
    x.ch    = ch;
    x.data  = data;
    x.done  = done;
    x.cyc   = c;
    q.push_back(x);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (adc_start_o) n_start++;
      if (result_valid_o || timeout_o) begin
        if (q.size() == 0) begin
          check("unexpected event", 1, 0);
        end else begin
          e = q.pop_front();
          check("event kind", int'(timeout_o), int'(e.is_to));
          check("event cycle", cyc, e.cyc);
          if (!e.is_to) begin
            check("result_ch", int'(result_ch_o), e.ch);
            check("result_data", int'(result_data_o), e.data);
            check("scan_done", int'(scan_done_o), int'(e.done));
          end else begin
            check("valid with timeout", int'(result_valid_o), 0);
          end
        end
      end else if (scan_done_o) begin
        check("scan_done without valid", 1, 0);
      end
    end
  end

  task automatic check_zero(string tag);
    check({tag, " adc_start"}, int'(adc_start_o), 0);
    check({tag, " ch_sel"}, int'(ch_sel_o), 0);
    check({tag, " busy"}, int'(busy_o), 0);
    check({tag, " valid"}, int'(result_valid_o), 0);
    check({tag, " result_ch"}, int'(result_ch_o), 0);
    check({tag, " result_data"}, int'(result_data_o), 0);
    check({tag, " scan_done"}, int'(scan_done_o), 0);
    check({tag, " timeout"}, int'(timeout_o), 0);
  endtask

  // Trigger is sampled at the next posedge, so START is cycle m+1.
  task automatic trigger(input logic [NC-1:0] m, input bit cont,
                         output int m_cyc);
    @(negedge clk);
    ch_mask    = m;
    continuous = cont;
    trig       = 1'b1;
    m_cyc      = cyc;
    @(negedge clk);
    trig = 1'b0;
  endtask

  int m;
  int s0;

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst    = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);

    // single scan 1011
    trigger(4'b1011, 1'b0, m);
    push(0, 0, 8'h01, 0, m + 12);
    push(0, 1, 8'h11, 0, m + 24);
    push(0, 3, 8'h31, 1, m + 36);
    repeat (35) @(negedge clk);
    check("single busy at last valid", int'(busy_o), 1);
    @(negedge clk);
    check("single busy after", int'(busy_o), 0);

    // continuous 0100, stopped during third WAIT_RDY
    s0 = n_start;
    trigger(4'b0100, 1'b1, m);
    push(0, 2, 8'h21, 1, m + 12);
    push(0, 2, 8'h21, 1, m + 24);
    push(0, 2, 8'h21, 1, m + 36);
    repeat (29) @(negedge clk);
    enable = 1'b0;
    repeat (7) @(negedge clk);
    check("cont busy after stop", int'(busy_o), 0);
    check("cont start count", n_start - s0, 3);
    enable = 1'b1;
    repeat (2) @(negedge clk);

    // stop request during ch1 WAIT_RDY of 1111
    trigger(4'b1111, 1'b0, m);
    push(0, 0, 8'h01, 0, m + 12);
    push(0, 1, 8'h11, 0, m + 24);
    repeat (17) @(negedge clk);
    enable = 1'b0;
    repeat (7) @(negedge clk);
    check("stop busy", int'(busy_o), 0);
    enable = 1'b1;
    repeat (4) @(negedge clk);

    // watchdog: ADC never samples
    never_sample = 1'b1;
    trigger(4'b0001, 1'b0, m);
    push(1, 0, 0, 0, m + 66);
    repeat (65) @(negedge clk);
    check("timeout busy", int'(busy_o), 0);
    never_sample = 1'b0;
    repeat (4) @(negedge clk);

    // stale ready held through the sample cycle
    stale_mode = 1'b1;
    trigger(4'b0011, 1'b0, m);
    push(0, 0, 8'h01, 0, m + 12);
    push(0, 1, 8'h11, 1, m + 24);
    repeat (26) @(negedge clk);
    stale_mode = 1'b0;

    // asynchronous reset mid-WAIT_RDY
    trigger(4'b0100, 1'b0, m);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("mid reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // ignored triggers: empty mask, then enable low
    s0 = n_start;
    trigger(4'b0000, 1'b0, m);
    enable = 1'b0;
    trigger(4'b1111, 1'b0, m);
    repeat (20) @(negedge clk);
    check("ignored trig starts", n_start - s0, 0);
    check("ignored trig busy", int'(busy_o), 0);

    repeat (4) @(negedge clk);
    check("scoreboard drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
